// File: rtl/frame_writer.sv
// frame_writer: captures one RGB888 video frame into BRAM as RGB332 and
// generates read addresses for playback of the stored frame.
//
// Ports:
//   clk          pixel clock, everything on its rising edge
//   reset_n      asynchronous active-low reset
//   capture_req  one-cycle request to capture the next full frame
//   read_en      level, drives playback read addresses while high
//   abort        level, forces BRAM_IDLE on the next edge
//   pixel_in     RGB888 {R,G,B}, aligned with hcount/vcount
//   hcount       current pixel column
//   vcount       current pixel line
//   bram_addr    registered BRAM address
//   bram_din     registered RGB332 write data
//   bram_we      registered BRAM write enable
//   bram_state   registered FSM state
//   frame_done   one-cycle pulse together with the last pixel write
//
// State          | meaning
// BRAM_IDLE      | waiting for capture_req or read_en
// CAPTURE_FRAME  | capture armed, waiting for the frame origin
// WRITING_FRAME  | writing active pixels of the frame to BRAM
// READING_FRAME  | generating read addresses while read_en is high
module frame_writer #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 400,
  parameter int ADDR_W   = 18
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              capture_req,
  input  logic              read_en,
  input  logic              abort,
  input  logic [23:0]       pixel_in,
  input  logic [10:0]       hcount,
  input  logic [9:0]        vcount,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [7:0]        bram_din,
  output logic              bram_we,
  output logic [1:0]        bram_state,
  output logic              frame_done
);

  typedef enum logic [1:0] {
    BRAM_IDLE     = 2'b00,
    CAPTURE_FRAME = 2'b01,
    WRITING_FRAME = 2'b10,
    READING_FRAME = 2'b11
  } state_t;

  localparam logic [11:0]       H_LIM     = 12'(H_ACTIVE);
  localparam logic [10:0]       V_LIM     = 11'(V_ACTIVE);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] wr_cnt, wr_cnt_nxt;
  logic [ADDR_W-1:0] rd_cnt, rd_cnt_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [7:0]        din_nxt;
  logic              we_nxt;
  logic              done_nxt;
  logic              active;
  logic              origin;
  logic [7:0]        pix_332;
  logic [ADDR_W-1:0] rd_base;

  assign active  = ({1'b0, hcount} < H_LIM) && ({1'b0, vcount} < V_LIM);
  assign origin  = (hcount == 11'd0) && (vcount == 10'd0);
  assign pix_332 = {pixel_in[23:21], pixel_in[15:13], pixel_in[7:6]};
  // Playback restarts at address 0 on the origin pixel itself.
  assign rd_base = origin ? '0 : rd_cnt;

  assign bram_state = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= BRAM_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    wr_cnt_nxt = wr_cnt;
    rd_cnt_nxt = rd_cnt;
    addr_nxt   = bram_addr;
    din_nxt    = bram_din;
    we_nxt     = 1'b0;
    done_nxt   = 1'b0;
    if (abort) begin
      state_nxt  = BRAM_IDLE;
      wr_cnt_nxt = '0;
    end else begin
      case (state)
        BRAM_IDLE: begin
          if (capture_req) begin
            state_nxt = CAPTURE_FRAME;
          end else if (read_en) begin
            state_nxt = READING_FRAME;
          end
        end
        CAPTURE_FRAME: begin
          // The origin pixel is written here so it is not lost to the
          // state change; the counter then continues from 1.
          if (origin) begin
            state_nxt  = WRITING_FRAME;
            we_nxt     = 1'b1;
            addr_nxt   = '0;
            din_nxt    = pix_332;
            wr_cnt_nxt = ADDR_W'(1);
            if (LAST_ADDR == '0) begin
              done_nxt   = 1'b1;
              state_nxt  = BRAM_IDLE;
              wr_cnt_nxt = '0;
            end
          end
        end
        WRITING_FRAME: begin
          if (active) begin
            we_nxt   = 1'b1;
            addr_nxt = wr_cnt;
            din_nxt  = pix_332;
            if (wr_cnt == LAST_ADDR) begin
              done_nxt   = 1'b1;
              state_nxt  = BRAM_IDLE;
              wr_cnt_nxt = '0;
            end else begin
              wr_cnt_nxt = wr_cnt + 1'b1;
            end
          end
        end
        READING_FRAME: begin
          if (!read_en) begin
            state_nxt = BRAM_IDLE;
          end
          if (active) begin
            addr_nxt   = rd_base;
            rd_cnt_nxt = rd_base + 1'b1;
          end
        end
        default: state_nxt = BRAM_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_cnt     <= '0;
      rd_cnt     <= '0;
      bram_addr  <= '0;
      bram_din   <= '0;
      bram_we    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      wr_cnt     <= wr_cnt_nxt;
      rd_cnt     <= rd_cnt_nxt;
      bram_addr  <= addr_nxt;
      bram_din   <= din_nxt;
      bram_we    <= we_nxt;
      frame_done <= done_nxt;
    end
  end

endmodule

// File: tb/tb_frame_writer.sv
// tb_frame_writer: directed bench for frame_writer on a reduced 40x25 active
// frame inside a 50x30 raster. Expected writes are queued as pixels are
// driven; a monitor pops and compares each write the DUT presents.
module tb_frame_writer;

  localparam int H_ACT = 40;
  localparam int V_ACT = 25;
  localparam int AW    = 10;
  localparam int H_TOT = 50;
  localparam int V_TOT = 30;
  localparam int TOTAL = H_ACT * V_ACT;

  typedef struct {
    int         addr;
    logic [7:0] din;
    bit         done;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          capture_req;
  logic          read_en;
  logic          abort;
  logic [23:0]   pixel_in;
  logic [10:0]   hcount;
  logic [9:0]    vcount;
  logic [AW-1:0] bram_addr;
  logic [7:0]    bram_din;
  logic          bram_we;
  logic [1:0]    bram_state;
  logic          frame_done;

  int   checks     = 0;
  int   errors     = 0;
  int   wr_count   = 0;
  int   done_count = 0;
  int   cx         = 0;
  int   cy         = 0;
  int   snap       = 0;
  bit   ren_lvl    = 1'b0;
  exp_t q[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  frame_writer #(.H_ACTIVE(H_ACT), .V_ACTIVE(V_ACT), .ADDR_W(AW)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .capture_req (capture_req),
    .read_en     (read_en),
    .abort       (abort),
    .pixel_in    (pixel_in),
    .hcount      (hcount),
    .vcount      (vcount),
    .bram_addr   (bram_addr),
    .bram_din    (bram_din),
    .bram_we     (bram_we),
    .bram_state  (bram_state),
    .frame_done  (frame_done)
  );

  function automatic logic [23:0] pix(input int x, input int y);
    if (x == 0 && y == 0) return 24'hFF8040;
    return {8'(x * 7 + 3), 8'(y * 13 + 1), 8'(x ^ y ^ 32'hA5)};
  endfunction

  function automatic logic [7:0] to_332(input logic [23:0] p);
    return {p[23:21], p[15:13], p[7:6]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Drive the pixel at the cursor on the falling edge, queue its expected
  // write when requested, then advance the raster cursor.
  task automatic step(input bit exp_w, input bit cap = 1'b0, input bit ab = 1'b0);
    logic [23:0] p;
    exp_t        e;
    @(negedge clk);
    p           = pix(cx, cy);
    hcount      = 11'(cx);
    vcount      = 10'(cy);
    pixel_in    = p;
    capture_req = cap;
    abort       = ab;
    read_en     = ren_lvl;
    if (exp_w && cx < H_ACT && cy < V_ACT) begin
      e.addr = cy * H_ACT + cx;
      e.din  = to_332(p);
      e.done = (e.addr == TOTAL - 1);
      q.push_back(e);
    end
    cx++;
    if (cx == H_TOT) begin
      cx = 0;
      cy++;
      if (cy == V_TOT) cy = 0;
    end
  endtask

  task automatic run_to(input int x, input int y, input bit exp_w);
    while (!(cx == x && cy == y)) step(exp_w);
  endtask

  // Outputs caused by the most recently driven pixel.
  task automatic peek();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (bram_we === 1'b1) begin
        wr_count++;
        if (frame_done === 1'b1) done_count++;
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write actual addr=%0d required no write at %0t", bram_addr, $time);
        end else begin
          mon_e = q.pop_front();
          chk("wr_addr", 32'(bram_addr), 32'(mon_e.addr));
          chk("wr_din", 32'(bram_din), 32'(mon_e.din));
          chk("wr_done", 32'(frame_done), 32'(mon_e.done));
        end
      end else if (frame_done === 1'b1) begin
        checks++;
        errors++;
        $display("FAIL done_without_write actual done=1 required 0 at %0t", $time);
      end
    end
  end

  initial begin
    reset_n     = 1'b0;
    capture_req = 1'b0;
    read_en     = 1'b0;
    abort       = 1'b0;
    pixel_in    = '0;
    hcount      = '0;
    vcount      = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", 32'(bram_state), 0);
    chk("rst_addr", 32'(bram_addr), 0);
    chk("rst_din", 32'(bram_din), 0);
    chk("rst_we", 32'(bram_we), 0);
    chk("rst_done", 32'(frame_done), 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Capture requested in blanking; waits for origin then writes the frame.
    repeat (5) step(0);
    peek();
    chk("idle_state", 32'(bram_state), 0);
    run_to(45, 27, 0);
    step(0, 1);
    peek();
    chk("capture_state", 32'(bram_state), 1);
    run_to(0, 0, 0);
    peek();
    chk("capture_hold_state", 32'(bram_state), 1);
    step(1);
    peek();
    chk("first_state", 32'(bram_state), 2);
    chk("first_we", 32'(bram_we), 1);
    chk("first_addr", 32'(bram_addr), 0);
    chk("first_din", 32'(bram_din), 32'h F1);
    run_to(40, 0, 1);
    step(1);
    peek();
    chk("hblank_we", 32'(bram_we), 0);
    run_to(0, 1, 1);
    step(1);
    peek();
    chk("line1_addr", 32'(bram_addr), 40);
    chk("line1_we", 32'(bram_we), 1);
    run_to(10, 5, 1);
    step(1, 1);
    peek();
    chk("recapture_ignored_state", 32'(bram_state), 2);
    run_to(39, 24, 1);
    step(1);
    peek();
    chk("last_addr", 32'(bram_addr), TOTAL - 1);
    chk("last_done", 32'(frame_done), 1);
    chk("last_state", 32'(bram_state), 0);
    run_to(0, 0, 0);
    chk("frame_writes", 32'(wr_count), TOTAL);
    chk("frame_done_count", 32'(done_count), 1);
    chk("queue_drained", 32'(q.size()), 0);

    // capture_req and read_en together: capture wins. Abort at counter 500.
    run_to(5, 0, 0);
    ren_lvl = 1'b1;
    step(0, 1);
    ren_lvl = 1'b0;
    peek();
    chk("cap_priority_state", 32'(bram_state), 1);
    run_to(0, 0, 0);
    run_to(20, 12, 1);
    step(0, 0, 1);
    peek();
    chk("abort_state", 32'(bram_state), 0);
    chk("abort_we", 32'(bram_we), 0);
    chk("abort_done", 32'(frame_done), 0);
    run_to(0, 0, 0);
    chk("abort_writes", 32'(wr_count), TOTAL + 500);
    chk("abort_done_count", 32'(done_count), 1);
    chk("abort_queue", 32'(q.size()), 0);

    // Playback addresses.
    ren_lvl = 1'b1;
    step(0);
    peek();
    chk("read_state", 32'(bram_state), 3);
    run_to(1, 1, 0);
    step(0, 1);
    peek();
    chk("read_cap_ignored", 32'(bram_state), 3);
    run_to(0, 0, 0);
    step(0);
    peek();
    chk("read_origin_addr", 32'(bram_addr), 0);
    chk("read_origin_we", 32'(bram_we), 0);
    run_to(5, 2, 0);
    step(0);
    peek();
    chk("read_5_2_addr", 32'(bram_addr), 85);
    chk("read_5_2_we", 32'(bram_we), 0);
    chk("read_5_2_state", 32'(bram_state), 3);
    run_to(39, 24, 0);
    step(0);
    peek();
    chk("read_last_addr", 32'(bram_addr), TOTAL - 1);
    ren_lvl = 1'b0;
    step(0);
    peek();
    chk("read_exit_state", 32'(bram_state), 0);
    chk("read_writes", 32'(wr_count), TOTAL + 500);

    // Reset in the middle of a capture discards it.
    run_to(30, 29, 0);
    step(0, 1);
    peek();
    chk("cap2_state", 32'(bram_state), 1);
    run_to(0, 0, 0);
    run_to(10, 3, 1);
    step(1);
    @(posedge clk);
    #2;
    chk("pre_reset_we", 32'(bram_we), 1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_state", 32'(bram_state), 0);
    chk("mid_rst_addr", 32'(bram_addr), 0);
    chk("mid_rst_din", 32'(bram_din), 0);
    chk("mid_rst_we", 32'(bram_we), 0);
    chk("mid_rst_done", 32'(frame_done), 0);
    q.delete();
    snap = wr_count;
    step(0);
    step(0);
    reset_n = 1'b1;
    run_to(0, 0, 0);
    step(0);
    run_to(0, 0, 0);
    peek();
    chk("post_rst_state", 32'(bram_state), 0);
    chk("post_rst_writes", 32'(wr_count), 32'(snap));
    chk("post_rst_done_count", 32'(done_count), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
